// File: rtl/ps2_pkg.sv
// PS/2 host transmitter shared types and constants.
// Used by ps2_host_tx and ps2_line_sync.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam int PS2_FRAME_BITS  = 11;
  localparam int PS2_INHIBIT_DEF = 5000;
  localparam int PS2_TIMEOUT_DEF = 100000;

  // 1 when the byte holds an even number of ones (odd parity)
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer with falling-edge detect for one PS/2 line.
// Flops reset to 1, the idle level of an open-drain line.
module ps2_line_sync (
  input  logic clock_fpga,
  input  logic reset,
  input  logic i_line,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clock_fpga) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, request, 11-bit frame).
// Define PS2_TX_TIMEOUT_EN to add the device-clock watchdog.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEF
) (
  input  logic       clock_fpga,
  input  logic       reset,
  input  logic       clock_key_in,
  input  logic       data_key_in,
  output logic       clock_key_oe,
  output logic       data_key_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int          IW       = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_BITS - 2);

  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ps2_host_tx: cycle parameters must be >= 1");
  end

  ps2_state_e r_state;
  ps2_state_e w_nxt;

  logic [IW-1:0] r_inh;
  logic [3:0]    r_bit;
  logic [7:0]    r_byte;
  logic          r_par;
  logic          r_doe;
  logic          r_nack;
  logic          r_done;
  logic          r_err;
  logic          w_done;
  logic          w_err;

  logic w_clk_sync;
  logic w_clk_fall;
  logic w_dat_sync;
  logic w_unused_dat_fall;
  logic w_timeout;

  ps2_line_sync u_clk_sync (
    .clock_fpga (clock_fpga),
    .reset      (reset),
    .i_line     (clock_key_in),
    .o_sync     (w_clk_sync),
    .o_fall     (w_clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clock_fpga (clock_fpga),
    .reset      (reset),
    .i_line     (data_key_in),
    .o_sync     (w_dat_sync),
    .o_fall     (w_unused_dat_fall)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_wdog;
  logic          w_wd_run;

  assign w_wd_run = (r_state == SEND) || (r_state == ACK) ||
                    (r_state == WAIT_IDLE);

  always_ff @(posedge clock_fpga) begin
    if (reset || !w_wd_run || w_clk_fall) r_wdog <= '0;
    else                                  r_wdog <= r_wdog + 1'b1;
  end

  assign w_timeout = w_wd_run && !w_clk_fall &&
                     (r_wdog == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_nxt  = r_state;
    w_done = 1'b0;
    w_err  = 1'b0;
    unique case (r_state)
      IDLE:      if (tx_start) w_nxt = INHIBIT;
      INHIBIT:   if (r_inh == IW'(INHIBIT_CYCLES - 1)) w_nxt = REQ;
      REQ:       w_nxt = SEND;
      SEND:      if (w_clk_fall && r_bit == LAST_BIT) w_nxt = ACK;
      ACK:       if (w_clk_fall) w_nxt = WAIT_IDLE;
      WAIT_IDLE: begin
        if (w_clk_sync && w_dat_sync) begin
          w_nxt  = IDLE;
          w_done = 1'b1;
          w_err  = r_nack;
        end
      end
      default:   w_nxt = IDLE;
    endcase
    if (w_timeout) begin
      w_nxt  = IDLE;
      w_done = 1'b1;
      w_err  = 1'b1;
    end
  end

  always_ff @(posedge clock_fpga) begin
    if (reset) begin
      r_state <= IDLE;
      r_inh   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_par   <= 1'b0;
      r_doe   <= 1'b0;
      r_nack  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_done  <= w_done;
      r_err   <= w_err;
      case (r_state)
        IDLE: begin
          r_inh  <= '0;
          r_bit  <= '0;
          r_doe  <= 1'b0;
          r_nack <= 1'b0;
          if (tx_start) begin
            r_byte <= tx_data;
            r_par  <= odd_parity(tx_data);
          end
        end
        INHIBIT: r_inh <= r_inh + 1'b1;
        REQ:     r_doe <= 1'b1;
        SEND: begin
          // open-drain: pulling low sends a 0
          if (w_clk_fall) begin
            r_bit <= r_bit + 1'b1;
            if (r_bit < 4'd8)       r_doe <= ~r_byte[r_bit[2:0]];
            else if (r_bit == 4'd8) r_doe <= ~r_par;
            else                    r_doe <= 1'b0;
          end
        end
        ACK:     if (w_clk_fall) r_nack <= w_dat_sync;
        default: ;
      endcase
    end
  end

  assign clock_key_oe = (r_state == INHIBIT) || (r_state == REQ);
  assign data_key_oe  = (r_state == REQ) || ((r_state == SEND) && r_doe);
  assign tx_busy      = (r_state != IDLE);
  assign tx_done      = r_done;
  assign tx_error     = r_err;

endmodule
